wave_uart_streamer: RTL and testbench

//  Downstream stage of the waveform selector: buffers 8-bit samples strobed from the waveform mux
//  and streams them out as 8N1 UART frames on TxD, back-to-back, with no per-byte handshake.

---
 rtl/wave_uart_streamer.sv | 130 +++++++++++++
 tb/tb_wave_uart_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_uart_streamer.sv
// Sample FIFO feeding an 8N1 UART transmitter; samples arriving while the FIFO
// is full are dropped and counted in a saturating overflow counter.
module wave_uart_streamer #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             sample_valid,
   input  logic [7:0]       sample_data,
   output logic             TxD,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count,
   output logic             fifo_full,
   output logic [7:0]       overflow_cnt
);

   // state | meaning
   // IDLE  | line high; pops the FIFO head when anything is queued
   // START | start bit (low) for one bit time
   // DATA  | eight data bits, LSB first
   // STOP  | stop bit (high) for one bit time

   localparam int BAUD_DIV = CLK_HZ / BAUD;
   localparam int BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             state, state_nxt;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   logic [7:0]         shift;
   logic [BW-1:0]      baud_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         ovf;
   logic               full, push, drop, pop, baud_done;

   // Full is judged on the registered count, so a push coinciding with a pop
   // while full is still dropped.
   assign full      = (count == DEPTH);
   assign push      = sample_valid & enable & ~full;
   assign drop      = sample_valid & enable & full;
   assign baud_done = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      TxD       = 1'b1;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            TxD = 1'b0;
            if (baud_done) state_nxt = DATA;
         end
         DATA: begin
            TxD = shift[0];
            if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: begin
            if (baud_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= sample_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         shift    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         ovf      <= '0;
      end else begin
         state <= state_nxt;

         if (push) tail <= tail + 1'b1;

         if (pop) begin
            shift    <= mem[head];
            head     <= head + 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
         end else if (state != IDLE) begin
            if (baud_done) begin
               baud_cnt <= '0;
               if (state == DATA) begin
                  bit_idx <= bit_idx + 3'd1;
                  shift   <= shift >> 1;
               end
            end else begin
               baud_cnt <= baud_cnt + 1'b1;
            end
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop && ovf != 8'hFF) ovf <= ovf + 8'd1;
      end
   end

   assign fifo_count   = count;
   assign fifo_full    = full;
   assign overflow_cnt = ovf;

endmodule

// File: tb/tb_wave_uart_streamer.sv
// Bench for wave_uart_streamer: a cycle model of FIFO occupancy and line timing,
// plus a scoreboard of accepted bytes checked bit-by-bit as frames leave TxD.
`timescale 1ns/1ps
module tb_wave_uart_streamer;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam int FRAME = 100;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable = 1'b0;
   logic             sample_valid = 1'b0;
   logic [7:0]       sample_data = 8'h00;
   logic             TxD, busy, fifo_full;
   logic [CNT_W-1:0] fifo_count;
   logic [7:0]       overflow_cnt;

   wave_uart_streamer #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
      .sample_data(sample_data), .TxD(TxD), .busy(busy), .fifo_count(fifo_count),
      .fifo_full(fifo_full), .overflow_cnt(overflow_cnt));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   int m_count = 0, m_ovf = 0, m_tmr = 0;
   bit m_valid = 0, m_pop, m_full;

   // Reference model: a frame occupies 100 clocks after its pop edge, then one idle clock.
   always @(posedge clk) begin
      m_valid = 1;
      if (!reset_n) begin
         m_count = 0; m_ovf = 0; m_tmr = 0;
         exp_q.delete();
      end else begin
         m_full = (m_count == DEPTH);
         m_pop  = (m_tmr == 0 && m_count != 0);
         if (m_pop) begin
            m_tmr = FRAME;
            m_count--;
         end else if (m_tmr != 0) begin
            m_tmr--;
         end
         if (sample_valid && enable) begin
            if (m_full) begin
               if (m_ovf < 255) m_ovf++;
            end else begin
               exp_q.push_back(sample_data);
               m_count++;
            end
         end
      end
   end

   int cyc = 0, mon_pos = -1, frame_err = 0, frames_done = 0, last_end = -1000;
   int peak = 0, busy_cyc = 0;
   bit gap_chk = 0;
   logic [7:0] cur = 8'h00;
   logic exp_bit;

   always @(negedge clk) begin
      cyc++;
      if (m_valid) begin
         checks++;
         if (fifo_count !== CNT_W'(m_count)) begin
            failures++; $display("FAIL model_count cyc=%0d got %0d exp %0d", cyc, fifo_count, m_count);
         end
         checks++;
         if (fifo_full !== (m_count == DEPTH)) begin
            failures++; $display("FAIL model_full cyc=%0d got %0b exp %0b", cyc, fifo_full, m_count == DEPTH);
         end
         checks++;
         if (overflow_cnt !== 8'(m_ovf)) begin
            failures++; $display("FAIL model_ovf cyc=%0d got %0d exp %0d", cyc, overflow_cnt, m_ovf);
         end
         checks++;
         if (busy !== (m_tmr != 0)) begin
            failures++; $display("FAIL model_busy cyc=%0d got %0b exp %0b", cyc, busy, m_tmr != 0);
         end
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         if (busy === 1'b1) busy_cyc++;
      end
      if (!reset_n) begin
         mon_pos = -1;
      end else if (mon_pos >= 0) begin
         mon_pos++;
         if (mon_pos < 10)      exp_bit = 1'b0;
         else if (mon_pos < 90) exp_bit = cur[(mon_pos - 10) / 10];
         else                   exp_bit = 1'b1;
         if (TxD !== exp_bit || busy !== 1'b1) frame_err++;
         if (mon_pos == FRAME - 1) begin
            checks++;
            if (frame_err != 0) begin
               failures++; $display("FAIL frame_bits byte=%02h bad_cycles got %0d exp 0", cur, frame_err);
            end
            frames_done++;
            last_end = cyc;
            mon_pos = -1;
         end
      end else if (m_valid && TxD === 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++; $display("FAIL unexpected_frame cyc=%0d got start bit exp idle", cyc);
            cur = 8'hxx;
         end else begin
            cur = exp_q.pop_front();
         end
         if (gap_chk) begin
            checks++;
            if (cyc - last_end - 1 != 1) begin
               failures++; $display("FAIL frame_gap got %0d exp 1", cyc - last_end - 1);
            end
         end
         mon_pos = 0;
         frame_err = (busy !== 1'b1) ? 1 : 0;
      end
   end

   task automatic drive(input logic [7:0] d);
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data  = d;
   endtask

   task automatic idle_in();
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic wait_drain(input int target);
      int n = 0;
      while ((frames_done < target || m_count != 0 || m_tmr != 0) && n < 5000) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 5000) begin
         failures++; $display("FAIL drain_timeout frames got %0d exp %0d", frames_done, target);
      end
      checks++;
      if (frames_done != target) begin
         failures++; $display("FAIL frame_count got %0d exp %0d", frames_done, target);
      end
   endtask

   task automatic test_reset();
      enable = 1'b1;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         sample_valid = (i != 1);
         sample_data  = 8'h30 + 8'(i);
         @(negedge clk);
         checks++;
         if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_hold got TxD=%b busy=%b cnt=%0d ovf=%0d exp 1 0 0 0", TxD, busy, fifo_count, overflow_cnt);
         end
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow_cnt !== 8'd0) begin
         failures++; $display("FAIL reset_release got TxD=%b busy=%b cnt=%0d ovf=%0d exp 1 0 0 0", TxD, busy, fifo_count, overflow_cnt);
      end
   endtask

   task automatic test_single_byte();
      int base = frames_done;
      drive(8'hA5);
      idle_in();
      @(negedge clk);
      busy_cyc = 0;
      checks++;
      if (fifo_count !== 3'd1 || TxD !== 1'b1) begin
         failures++; $display("FAIL push_latency got cnt=%0d TxD=%b exp 1 1", fifo_count, TxD);
      end
      @(negedge clk);
      checks++;
      if (TxD !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL pop_latency got TxD=%b busy=%b cnt=%0d exp 0 1 0", TxD, busy, fifo_count);
      end
      wait_drain(base + 1);
      checks++;
      if (busy_cyc != FRAME) begin
         failures++; $display("FAIL busy_length got %0d exp %0d", busy_cyc, FRAME);
      end
   endtask

   task automatic test_back_to_back();
      int base = frames_done;
      int n = 0;
      gap_chk = 0;
      peak = 0;
      for (int i = 1; i <= 4; i++) drive(8'(i));
      idle_in();
      while (frames_done < base + 1 && n < 500) begin @(negedge clk); n++; end
      gap_chk = 1;
      wait_drain(base + 4);
      gap_chk = 0;
      checks++;
      if (peak != 3) begin
         failures++; $display("FAIL burst_peak got %0d exp 3", peak);
      end
      checks++;
      if (overflow_cnt !== 8'd0) begin
         failures++; $display("FAIL burst_ovf got %0d exp 0", overflow_cnt);
      end
   endtask

   task automatic test_overflow();
      int base = frames_done;
      int n = 0;
      drive(8'h10);
      for (int i = 1; i <= 6; i++) drive(8'h10 + 8'(i));
      idle_in();
      @(negedge clk);
      checks++;
      if (fifo_full !== 1'b1 || fifo_count !== 3'd4 || overflow_cnt !== 8'd2) begin
         failures++; $display("FAIL overflow_fill got full=%b cnt=%0d ovf=%0d exp 1 4 2", fifo_full, fifo_count, overflow_cnt);
      end
      do begin
         @(posedge clk); #1; n++;
      end while (!(m_tmr == 0 && m_count == DEPTH) && n < 400);
      sample_valid = 1'b1;
      sample_data  = 8'hEE;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (overflow_cnt !== 8'd3 || fifo_count !== 3'd3 || fifo_full !== 1'b0) begin
         failures++; $display("FAIL push_at_full_pop got ovf=%0d cnt=%0d full=%b exp 3 3 0", overflow_cnt, fifo_count, fifo_full);
      end
      wait_drain(base + 5);
   endtask

   task automatic test_enable_low();
      int base = frames_done;
      drive(8'h21);
      drive(8'h22);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(8'h90 + 8'(i));
         idle_in();
      end
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd1 || overflow_cnt !== 8'd3) begin
         failures++; $display("FAIL enable_low got cnt=%0d ovf=%0d exp 1 3", fifo_count, overflow_cnt);
      end
      wait_drain(base + 2);
      enable = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      int base = frames_done;
      int n = 0;
      drive(8'h55);
      drive(8'h77);
      idle_in();
      do begin
         @(posedge clk); #1; n++;
      end while (mon_pos < 44 && n < 200);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL reset_mid_frame got TxD=%b busy=%b cnt=%0d exp 1 0 0", TxD, busy, fifo_count);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      checks++;
      if (frames_done != base) begin
         failures++; $display("FAIL aborted_frame_count got %0d exp %0d", frames_done, base);
      end
      drive(8'h3C);
      idle_in();
      wait_drain(base + 1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_enable_low();
      test_reset_mid_frame();
      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
